// File: rtl/kbd_ps2_if.sv
// PS/2 pins plus decoded keyboard outputs, shared between the receiver and its user.
interface kbd_ps2_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] kbd_out;
   logic        scan_valid;
   logic [7:0]  scan_byte;
   logic        frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  kbd_out, scan_valid, scan_byte, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output kbd_out, scan_valid, scan_byte, frame_err
   );
endinterface

// File: rtl/kbd_ps2.sv
// PS/2 scan-set-2 receiver: synchronise pins, deframe bytes, track E0/F0 prefixes,
// and hold the Hack code of the most recently pressed, still-held key.
module kbd_ps2 #(
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic      clk,
   input  logic      reset,
   kbd_ps2_if.slave  bus
);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state, state_n;
   logic [2:0]    cnt, cnt_n;
   logic [7:0]    shf, shf_n;
   logic          par, par_n;
   logic [TW-1:0] tmo, tmo_n;
   logic          valid_n, err_n, clr_n;
   logic          clr_q;
   logic          ck1, ck2, ck3, dt1, dt2;
   logic          fall_c, tmo_hit_c;
   logic          brk, ext;
   logic [15:0]   code_c;

   // Two-flop synchronisers plus a delayed copy of the clock for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ck1 <= 1'b1; ck2 <= 1'b1; ck3 <= 1'b1;
         dt1 <= 1'b1; dt2 <= 1'b1;
      end else begin
         ck1 <= bus.ps2_clk;  ck2 <= ck1; ck3 <= ck2;
         dt1 <= bus.ps2_data; dt2 <= dt1;
      end
   end

   assign fall_c    = ck3 & ~ck2;
   assign tmo_hit_c = (state != IDLE) && !fall_c && (tmo == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         shf            <= '0;
         par            <= 1'b0;
         tmo            <= '0;
         clr_q          <= 1'b0;
         bus.scan_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.scan_byte  <= '0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         shf            <= shf_n;
         par            <= par_n;
         tmo            <= tmo_n;
         clr_q          <= clr_n;
         bus.scan_valid <= valid_n;
         bus.frame_err  <= err_n;
         if (valid_n) bus.scan_byte <= shf;
      end
   end

   // Frame FSM; par accumulates the XOR of data and parity bits (must end at 1)
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shf_n   = shf;
      par_n   = par;
      valid_n = 1'b0;
      err_n   = 1'b0;
      clr_n   = 1'b0;
      tmo_n   = (fall_c || state == IDLE) ? '0 : tmo + TW'(1);
      if (tmo_hit_c) begin
         state_n = IDLE;
         err_n   = 1'b1;
      end else if (fall_c) begin
         unique case (state)
            IDLE: if (!dt2) begin
               state_n = DATA;
               cnt_n   = '0;
               par_n   = 1'b0;
            end
            DATA: begin
               shf_n = {dt2, shf[7:1]};
               par_n = par ^ dt2;
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               par_n   = par ^ dt2;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (par && dt2) begin
                  valid_n = 1'b1;
               end else begin
                  err_n = 1'b1;
                  clr_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Scan-set-2 to Hack key code; 0 means unmapped
   always_comb begin
      code_c = '0;
      if (!ext) begin
         case (bus.scan_byte)
            8'h1C: code_c = 16'd65;  8'h32: code_c = 16'd66;  8'h21: code_c = 16'd67;
            8'h23: code_c = 16'd68;  8'h24: code_c = 16'd69;  8'h2B: code_c = 16'd70;
            8'h34: code_c = 16'd71;  8'h33: code_c = 16'd72;  8'h43: code_c = 16'd73;
            8'h3B: code_c = 16'd74;  8'h42: code_c = 16'd75;  8'h4B: code_c = 16'd76;
            8'h3A: code_c = 16'd77;  8'h31: code_c = 16'd78;  8'h44: code_c = 16'd79;
            8'h4D: code_c = 16'd80;  8'h15: code_c = 16'd81;  8'h2D: code_c = 16'd82;
            8'h1B: code_c = 16'd83;  8'h2C: code_c = 16'd84;  8'h3C: code_c = 16'd85;
            8'h2A: code_c = 16'd86;  8'h1D: code_c = 16'd87;  8'h22: code_c = 16'd88;
            8'h35: code_c = 16'd89;  8'h1A: code_c = 16'd90;
            8'h45: code_c = 16'd48;  8'h16: code_c = 16'd49;  8'h1E: code_c = 16'd50;
            8'h26: code_c = 16'd51;  8'h25: code_c = 16'd52;  8'h2E: code_c = 16'd53;
            8'h36: code_c = 16'd54;  8'h3D: code_c = 16'd55;  8'h3E: code_c = 16'd56;
            8'h46: code_c = 16'd57;
            8'h29: code_c = 16'd32;  8'h5A: code_c = 16'd128;
            8'h66: code_c = 16'd129; 8'h76: code_c = 16'd140;
            default: code_c = '0;
         endcase
      end else begin
         case (bus.scan_byte)
            8'h6B: code_c = 16'd130; 8'h75: code_c = 16'd131;
            8'h74: code_c = 16'd132; 8'h72: code_c = 16'd133;
            default: code_c = '0;
         endcase
      end
   end

   // Key tracker: last make wins, break clears only the currently held key
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         brk         <= 1'b0;
         ext         <= 1'b0;
         bus.kbd_out <= '0;
      end else if (clr_q) begin
         brk <= 1'b0;
         ext <= 1'b0;
      end else if (bus.scan_valid) begin
         if (bus.scan_byte == 8'hF0) begin
            brk <= 1'b1;
         end else if (bus.scan_byte == 8'hE0) begin
            ext <= 1'b1;
         end else begin
            brk <= 1'b0;
            ext <= 1'b0;
            if (code_c != '0) begin
               if (!brk)                      bus.kbd_out <= code_c;
               else if (code_c == bus.kbd_out) bus.kbd_out <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_kbd_ps2.sv
// Directed bench for kbd_ps2: table of frames with expected key codes plus
// hand sequences for output latency, timeout and mid-frame reset.
module tb_kbd_ps2;
   localparam int unsigned TIMEOUT = 5000;
   localparam int unsigned HALF    = 20;

   logic clk = 1'b0;
   logic reset = 1'b1;
   kbd_ps2_if bus ();

   kbd_ps2 #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_valid = 0;
   int n_err = 0;
   logic [7:0] last_byte = 8'h00;

   always @(negedge clk) begin
      if (bus.scan_valid) begin
         n_valid++;
         last_byte = bus.scan_byte;
      end
      if (bus.frame_err) n_err++;
   end

   typedef struct {
      logic [7:0]  b;
      bit          bad;
      logic [15:0] kbd;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Drive the first nbits of a frame: start, 8 data LSB first, odd parity, stop
   task automatic send_bits(input logic [7:0] b, input bit flip, input int nbits);
      logic [10:0] fr;
      logic        p;
      p  = ~^b ^ flip;
      fr = {1'b1, p, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = fr[i];
         wait_clk(HALF);
         bus.ps2_clk = 1'b0;
         wait_clk(HALF);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_bits(b, 1'b0, 11);
      wait_clk(8);
   endtask

   int v0, e0;
   logic [15:0] k_at_valid;
   bit seen;

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      vecs = '{
         '{8'h1C, 1'b0, 16'd65},  '{8'hF0, 1'b0, 16'd65},  '{8'h1C, 1'b0, 16'd0},
         '{8'hE0, 1'b0, 16'd0},   '{8'h75, 1'b0, 16'd131}, '{8'hE0, 1'b0, 16'd131},
         '{8'hF0, 1'b0, 16'd131}, '{8'h75, 1'b0, 16'd0},   '{8'hE0, 1'b0, 16'd0},
         '{8'h5A, 1'b0, 16'd0},   '{8'h5A, 1'b0, 16'd128}, '{8'h1C, 1'b0, 16'd65},
         '{8'h32, 1'b0, 16'd66},  '{8'hF0, 1'b0, 16'd66},  '{8'h1C, 1'b0, 16'd66},
         '{8'hF0, 1'b0, 16'd66},  '{8'h32, 1'b0, 16'd0},   '{8'h1C, 1'b1, 16'd0},
         '{8'h1C, 1'b0, 16'd65},  '{8'h1C, 1'b0, 16'd65},  '{8'hF0, 1'b0, 16'd65},
         '{8'h1C, 1'b1, 16'd65},  '{8'h45, 1'b0, 16'd48},  '{8'hE0, 1'b0, 16'd48},
         '{8'h75, 1'b1, 16'd48},  '{8'h75, 1'b0, 16'd48},  '{8'h76, 1'b0, 16'd140},
         '{8'h66, 1'b0, 16'd129}, '{8'hE0, 1'b0, 16'd129}, '{8'h6B, 1'b0, 16'd130},
         '{8'hE0, 1'b0, 16'd130}, '{8'h74, 1'b0, 16'd132}, '{8'hE0, 1'b0, 16'd132},
         '{8'h72, 1'b0, 16'd133}, '{8'h46, 1'b0, 16'd57},  '{8'hF0, 1'b0, 16'd57},
         '{8'h46, 1'b0, 16'd0}
      };

      wait_clk(3);
      @(negedge clk);
      check("reset kbd_out",    32'(bus.kbd_out),    32'd0);
      check("reset scan_valid", 32'(bus.scan_valid), 32'd0);
      check("reset scan_byte",  32'(bus.scan_byte),  32'd0);
      check("reset frame_err",  32'(bus.frame_err),  32'd0);
      reset = 1'b0;
      wait_clk(5);

      foreach (vecs[i]) begin
         v0 = n_valid;
         e0 = n_err;
         send_bits(vecs[i].b, vecs[i].bad, 11);
         wait_clk(8);
         @(negedge clk);
         check($sformatf("vec%0d kbd_out", i), 32'(bus.kbd_out), 32'(vecs[i].kbd));
         check($sformatf("vec%0d valid_cnt", i), 32'(n_valid - v0), vecs[i].bad ? 32'd0 : 32'd1);
         check($sformatf("vec%0d err_cnt", i), 32'(n_err - e0), vecs[i].bad ? 32'd1 : 32'd0);
         if (!vecs[i].bad)
            check($sformatf("vec%0d scan_byte", i), 32'(last_byte), 32'(vecs[i].b));
      end

      // Output latency: kbd_out must lag the scan_valid pulse by exactly one cycle
      send_bits(8'h29, 1'b0, 10);
      bus.ps2_data = 1'b1;
      wait_clk(HALF);
      bus.ps2_clk = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (bus.scan_valid) begin
            seen = 1'b1;
            k_at_valid = bus.kbd_out;
         end
      end
      check("latency valid seen", 32'(seen), 32'd1);
      if (seen) begin
         check("latency kbd at valid", 32'(k_at_valid), 32'd0);
         check("latency byte at valid", 32'(bus.scan_byte), 32'h29);
         @(negedge clk);
         check("latency valid one cycle", 32'(bus.scan_valid), 32'd0);
         check("latency kbd next", 32'(bus.kbd_out), 32'd32);
      end
      wait_clk(HALF);
      bus.ps2_clk = 1'b1;
      wait_clk(HALF);

      // Timeout abandons a partial frame but keeps the break prefix
      send(8'hF0);
      v0 = n_valid;
      e0 = n_err;
      send_bits(8'h1C, 1'b0, 5);
      wait_clk(TIMEOUT + 10);
      @(negedge clk);
      check("timeout err_cnt", 32'(n_err - e0), 32'd1);
      check("timeout valid_cnt", 32'(n_valid - v0), 32'd0);
      check("timeout kbd_out", 32'(bus.kbd_out), 32'd32);
      send(8'h29);
      @(negedge clk);
      check("timeout brk kept", 32'(bus.kbd_out), 32'd0);
      send(8'h29);
      @(negedge clk);
      check("after timeout 29", 32'(bus.kbd_out), 32'd32);
      check("after timeout err_cnt", 32'(n_err - e0), 32'd1);

      // Reset mid-frame clears the held key at once and issues no pulse
      send(8'h45);
      @(negedge clk);
      check("pre-reset kbd_out", 32'(bus.kbd_out), 32'd48);
      v0 = n_valid;
      e0 = n_err;
      send_bits(8'h1C, 1'b0, 5);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset async kbd_out", 32'(bus.kbd_out), 32'd0);
      wait_clk(3);
      @(negedge clk);
      reset = 1'b0;
      wait_clk(20);
      @(negedge clk);
      check("reset no valid", 32'(n_valid - v0), 32'd0);
      check("reset no err", 32'(n_err - e0), 32'd0);
      send(8'h1C);
      @(negedge clk);
      check("post-reset 1C", 32'(bus.kbd_out), 32'd65);
      check("post-reset valid", 32'(n_valid - v0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
